sha1_in_word_fifo: RTL
======================

SHA1_IN_WORD_FIFO -- requirements
Module: sha1_in_word_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of one SHA-1 input word.
REQ-002 Parameter DEPTH, default 8, number of word entries; power of two, at most 8.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port clear  input  1  synchronous flush of contents and flags.
REQ-006 Port wr_en  input  1  write strobe from the HPS-side word-write register.
REQ-007 Port wr_data  input  DATA_W  word to enqueue.
REQ-008 Port rd_ready  input  1  SHA-1 core accepts the head word this cycle.
REQ-009 Port rd_valid  output  1  head word present.
REQ-010 Port rd_data  output  DATA_W  head word (show-ahead).
REQ-011 Port full  output  1  occupancy equals DEPTH.
REQ-012 Port overflow  output  1  sticky: a write was dropped.
REQ-013 Port count  output  4  occupancy 0..DEPTH; drives the 4-bit in_port of the send-in count PIO.

Function
REQ-014 Push occurs when wr_en=1 and full=0; wr_data is stored at the write pointer.
REQ-015 Pop occurs when rd_valid=1 and rd_ready=1; the read pointer advances.
REQ-016 A push is not permitted while full=1, even if a pop occurs in the same cycle; the word is dropped and overflow is set to 1 at the next edge.
REQ-017 rd_ready while rd_valid=0 has no effect (no underflow, pointers unchanged).
REQ-018 count, full and rd_valid are registered and reflect occupancy after the current edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-019 rd_valid = (count != 0); full = (count == DEPTH).
REQ-020 Latency: a word pushed at edge N is visible on rd_data with rd_valid=1 after edge N (first cycle N+1) when the FIFO was empty.
REQ-021 rd_data holds the head word stably while rd_valid=1 and no pop occurs.
REQ-022 Output order is strict FIFO order; pointers are log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-023 clear=1 sets count=0 and both pointers to 0, and sets overflow=0. It overrides any push or pop in the same cycle.
REQ-024 overflow stays 1 until clear or reset; later successful pushes do not clear it.
REQ-025 The contents of storage entries are not reset; rd_data is don't-care while rd_valid=0.

Reset
REQ-026 When reset_n=0, the following are cleared asynchronously: count=0, pointers=0, rd_valid=0, full=0, overflow=0.
REQ-027 Reset asserted mid-operation discards all queued words; after release, the first push behaves as in REQ-020.
REQ-028 Reset is released on clk synchronously with respect to internal state; no push or pop is recognised on the release edge while reset_n is still 0.

Structure
REQ-029 Package sha1_pkg holds DATA_W, DEPTH, CNT_W=4 and the word type; the top-level and the SHA-1 core share it.
REQ-030 Storage is one sub-module, sha1_fifo_mem: DEPTH x DATA_W register array with 1 write port and an asynchronous read port.
REQ-031 Pointers, count, flags and the push/pop decode live in sha1_in_word_fifo.

Verification
REQ-032 Reset, then push 0x67452301 with rd_ready=0 -> next cycle rd_valid=1, rd_data=0x67452301, count=1.
REQ-033 Push 8 words 1..8 with rd_ready=0, then a 9th word 9 -> full=1, count=8, overflow=1; then pop 8 words -> data 1..8 in order, count=0.
REQ-034 With count=3, push and pop in the same cycle for 20 cycles -> count stays 3, order preserved across pointer wrap.
REQ-035 With full=1, wr_en=1 and rd_ready=1 together -> pop succeeds, word dropped, count=7, overflow=1.
REQ-036 With count=5 and overflow=1, assert clear together with wr_en -> count=0, rd_valid=0, overflow=0 on the next cycle.
REQ-037 Assert reset_n=0 asynchronously mid-burst at count=4 -> count=0 and rd_valid=0 without waiting for a clk edge.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 input-path definitions: word width, FIFO depth, and the
// occupancy-count width used by the send-in count PIO.
`timescale 1ns/1ps
package sha1_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/sha1_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately left unreset.
`timescale 1ns/1ps
module sha1_fifo_mem #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sha1_in_word_fifo.sv
// Show-ahead word FIFO between the HPS word-write register and the SHA-1 core.
// Pointers, registered count/flags and a sticky overflow live here.
`timescale 1ns/1ps
module sha1_in_word_fifo
    import sha1_pkg::CNT_W;
#(
    parameter int DATA_W = sha1_pkg::DATA_W,
    parameter int DEPTH  = sha1_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_full;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;

    // A full FIFO refuses the write even when a pop frees a slot this cycle.
    assign w_push = wr_en & ~r_full;
    assign w_drop = wr_en & r_full;
    assign w_pop  = r_valid & rd_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == DEPTH_C);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sha1_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push & ~clear),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    assign rd_valid = r_valid;
    assign full     = r_full;
    assign overflow = r_overflow;
    assign count    = r_count;

endmodule
